// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the DDS phase accumulator
package dds_pkg;

    // Default geometry: 32-bit phase, 12-bit ROM address (matches sin_rom)
    localparam int DEFAULT_PHASE_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH  = 12;

    // Dither LFSR: x^16 + x^15 + x^13 + x^4 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    // Generator control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One Galois step: shift right, fold the tap mask in when bit 0 falls out
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/dds_lfsr.sv
// rtl/dds_lfsr.sv - 16-bit Galois LFSR used as phase dither source
module dds_lfsr
    import dds_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Advance only while enabled so the sequence is frozen between bursts
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // State register; reseeded on reset so the dither sequence is repeatable
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - DDS phase accumulator / sin_rom address generator (optional PHASE_DITHER_EN)
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   stop_at_wrap,
    input  logic                   cfg_wr,
    input  logic [PHASE_WIDTH-1:0] cfg_fword,
    input  logic [PHASE_WIDTH-1:0] cfg_pword,
    input  logic                   cfg_sync,
    output logic                   cfg_busy,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   addr_vld,
    output logic                   wrap,
    output logic                   running
);

    state_t                 state_q,     state_d;
    logic [PHASE_WIDTH-1:0] acc_q,       acc_d;
    logic [PHASE_WIDTH-1:0] fword_act_q, fword_act_d;
    logic [PHASE_WIDTH-1:0] pword_act_q, pword_act_d;
    logic [PHASE_WIDTH-1:0] fword_shd_q, fword_shd_d;
    logic [PHASE_WIDTH-1:0] pword_shd_q, pword_shd_d;
    logic                   pending_q,   pending_d;
    logic                   sync_q,      sync_d;
    logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;
    logic                   addr_vld_q,  addr_vld_d;
    logic                   wrap_q,      wrap_d;

    logic                   active;
    logic [PHASE_WIDTH:0]   acc_sum;
    logic                   carry;
    logic [PHASE_WIDTH-1:0] phase_out;

    // Generating whenever not idle; this also gates the output stage
    assign active  = (state_q != IDLE);

    // One extra bit on the add exposes the period-wrap carry
    assign acc_sum = {1'b0, acc_q} + {1'b0, fword_act_q};
    assign carry   = acc_sum[PHASE_WIDTH];

`ifdef PHASE_DITHER_EN
    // Only the bits that truncation throws away get dithered, capped at the LFSR width
    localparam int DITHER_BITS = ((PHASE_WIDTH - ADDR_WIDTH) < 16) ?
                                 (PHASE_WIDTH - ADDR_WIDTH) : 16;

    logic [15:0]            lfsr;
    logic [PHASE_WIDTH-1:0] dither;

    dds_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (active),
        .lfsr_o (lfsr)
    );

    if (DITHER_BITS > 0) begin : g_dither
        assign dither = PHASE_WIDTH'(lfsr[DITHER_BITS-1:0]);
    end else begin : g_no_dither
        assign dither = '0;
    end

    assign phase_out = acc_q + pword_act_q + dither;
`else
    assign phase_out = acc_q + pword_act_q;
`endif

    // Next-state: control FSM, config double-buffer and registered output stage
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fword_act_d = fword_act_q;
        pword_act_d = pword_act_q;
        fword_shd_d = fword_shd_q;
        pword_shd_d = pword_shd_q;
        pending_d   = pending_q;
        sync_d      = sync_q;
        addr_d      = addr_q;
        addr_vld_d  = 1'b0;
        wrap_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // stop is meaningless here, so start always wins a tie
                if (start) begin
                    state_d = RUN;
                    acc_d   = '0;
                end
            end
            RUN: begin
                acc_d = acc_sum[PHASE_WIDTH-1:0];
                if (stop) begin
                    state_d = stop_at_wrap ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                // Finish the current period; the carrying sample is the last one
                acc_d = acc_sum[PHASE_WIDTH-1:0];
                if (carry) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Apply shadow: at once when idle or unsynchronised, else on the carry edge.
        // On that carry edge the accumulate above still uses the old fword.
        if (pending_q && (!active || !sync_q || carry)) begin
            fword_act_d = fword_shd_q;
            pword_act_d = pword_shd_q;
            pending_d   = 1'b0;
        end

        // A new write always re-arms, even if an older value applies on this edge
        if (cfg_wr) begin
            fword_shd_d = cfg_fword;
            pword_shd_d = cfg_pword;
            pending_d   = 1'b1;
            sync_d      = cfg_sync;
        end

        // Output sample reflects the accumulator value before this edge's step
        if (active) begin
            addr_d     = phase_out[PHASE_WIDTH-1 -: ADDR_WIDTH];
            addr_vld_d = 1'b1;
            wrap_d     = carry;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            fword_act_q <= '0;
            pword_act_q <= '0;
            fword_shd_q <= '0;
            pword_shd_q <= '0;
            pending_q   <= 1'b0;
            sync_q      <= 1'b0;
            addr_q      <= '0;
            addr_vld_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fword_act_q <= fword_act_d;
            pword_act_q <= pword_act_d;
            fword_shd_q <= fword_shd_d;
            pword_shd_q <= pword_shd_d;
            pending_q   <= pending_d;
            sync_q      <= sync_d;
            addr_q      <= addr_d;
            addr_vld_q  <= addr_vld_d;
            wrap_q      <= wrap_d;
        end
    end

    assign addr     = addr_q;
    assign addr_vld = addr_vld_q;
    assign wrap     = wrap_q;
    assign cfg_busy = pending_q;
    assign running  = active;

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb/tb_dds_phase_acc.sv - directed self-checking bench for dds_phase_acc
module tb_dds_phase_acc;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        stop_at_wrap;
    logic        cfg_wr;
    logic [31:0] cfg_fword;
    logic [31:0] cfg_pword;
    logic        cfg_sync;
    logic        cfg_busy;
    logic [11:0] addr;
    logic        addr_vld;
    logic        wrap;
    logic        running;

    int n_checks = 0;
    int n_pass   = 0;

    dds_phase_acc dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .stop_at_wrap (stop_at_wrap),
        .cfg_wr       (cfg_wr),
        .cfg_fword    (cfg_fword),
        .cfg_pword    (cfg_pword),
        .cfg_sync     (cfg_sync),
        .cfg_busy     (cfg_busy),
        .addr         (addr),
        .addr_vld     (addr_vld),
        .wrap         (wrap),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [31:0] fw, input logic [31:0] pw, input logic sy);
        cfg_wr = 1'b1; cfg_fword = fw; cfg_pword = pw; cfg_sync = sy;
        step();
        cfg_wr = 1'b0;
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; stop = 1'b0; stop_at_wrap = 1'b0;
        cfg_wr = 1'b0; cfg_fword = '0; cfg_pword = '0; cfg_sync = 1'b0;

        // Reset state
        step(); step();
        check("rst_addr", addr, 0);
        check("rst_vld", addr_vld, 0);
        check("rst_wrap", wrap, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_running", running, 0);
        rst = 1'b0;

        // 1: fword 2^20 steps the address by one; wrap marks addr 4095
        cfg(32'h0010_0000, 32'h0, 1'b0);
        check("t1_busy_set", cfg_busy, 1);
        step();
        check("t1_busy_idle_apply", cfg_busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_running", running, 1);
        check("t1_vld_latency", addr_vld, 0);
        step();
        check("t1_first_vld", addr_vld, 1);
        check("t1_first_addr", addr, 0);
        check("t1_first_wrap", wrap, 0);
        bad = 0;
        for (int i = 1; i < 8192; i++) begin
            step();
            if (addr !== 12'(i % 4096) || addr_vld !== 1'b1 ||
                wrap !== ((i % 4096) == 4095)) bad++;
        end
        check("t1_two_periods_bad", bad, 0);
        check("t1_wrap_at_4095", {addr, 3'b0, wrap}, {12'd4095, 3'b0, 1'b1});

        // 2: synchronous fword change takes effect at the wrap edge
        for (int i = 0; i < 101; i++) step();
        check("t2_pre_addr", addr, 100);
        cfg(32'h0020_0000, 32'h0, 1'b1);
        check("t2_write_addr", addr, 101);
        check("t2_busy", cfg_busy, 1);
        bad = 0;
        for (int i = 102; i < 4096; i++) begin
            step();
            if (addr !== 12'(i) || cfg_busy !== (i < 4095) || wrap !== (i == 4095)) bad++;
        end
        check("t2_hold_bad", bad, 0);
        check("t2_busy_clear", cfg_busy, 0);
        step();
        check("t2_after_wrap", addr, 0);
        step();
        check("t2_step2_a", addr, 2);
        step();
        check("t2_step2_b", addr, 4);

        // 3: immediate phase offset of half a turn, accumulator untouched
        cfg(32'h0020_0000, 32'h8000_0000, 1'b0);
        check("t3_addr_a", addr, 6);
        step();
        check("t3_addr_b", addr, 8);
        step();
        check("t3_jump", addr, 2058);
        step();
        check("t3_after_jump", addr, 2060);

        // 4a: stop at wrap finishes the period
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg(32'h0010_0000, 32'h0, 1'b0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("t4_addr10", addr, 10);
        stop = 1'b1; stop_at_wrap = 1'b1;
        step();
        stop = 1'b0; stop_at_wrap = 1'b0;
        check("t4_drain_running", running, 1);
        check("t4_drain_addr", addr, 11);
        bad = 0;
        for (int i = 12; i < 4096; i++) begin
            step();
            if (addr !== 12'(i) || addr_vld !== 1'b1 || wrap !== (i == 4095)) bad++;
        end
        check("t4_drain_bad", bad, 0);
        check("t4_last_wrap", wrap, 1);
        check("t4_idle_at_wrap", running, 0);
        step();
        check("t4_vld_off", addr_vld, 0);
        check("t4_wrap_off", wrap, 0);
        check("t4_addr_hold", addr, 4095);

        // 4b: immediate stop
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t4b_restart_addr", addr, 0);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4b_running", running, 0);
        check("t4b_last_sample", {addr, 3'b0, addr_vld}, {12'd2, 3'b0, 1'b1});
        step();
        check("t4b_vld_off", addr_vld, 0);
        check("t4b_addr_hold", addr, 2);

        // 5: reset mid-run with a pending synchronous config
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        cfg(32'h0030_0000, 32'h0, 1'b1);
        check("t5_busy", cfg_busy, 1);
        check("t5_addr", addr, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_outs", {addr, addr_vld, wrap, cfg_busy, running}, 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5_start_addr", {addr, 3'b0, addr_vld}, {12'd0, 3'b0, 1'b1});
        step();
        check("t5_fword0_addr", addr, 0);

        // 6: start+stop from IDLE enters RUN; fword 0 holds the phase offset
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("t6_idle", running, 0);
        cfg(32'h0, 32'h4560_0000, 1'b0);
        step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t6_start_wins", running, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (addr !== 12'h456 || addr_vld !== 1'b1 || wrap !== 1'b0) bad++;
        end
        check("t6_const_bad", bad, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t6_stop_wins", running, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
